// File: rtl/sid_bus_sched_pkg.sv
// ============================================================================
// Module : sid_sched_pkg
// Brief  : Shared types and constants for the SID write-back scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sid_sched_pkg;

  localparam int SID_NUM_REGS         = 32;
  localparam int SID_PHI2_DIV_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } sched_state_e;

endpackage

`default_nettype wire

// File: rtl/ram.sv
// ============================================================================
// Module : ram
// Brief  : Distributed register RAM, synchronous write, combinational read.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ram #(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = 5
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [RAM_ADDR_BITS-1:0] wr_addr,
  input  logic [RAM_WIDTH-1:0]     wr_data,
  input  logic [RAM_ADDR_BITS-1:0] read_addr,
  output logic [RAM_WIDTH-1:0]     read_data
);

  logic [RAM_WIDTH-1:0] mem_q [(1<<RAM_ADDR_BITS)];

  // Contents are deliberately left unreset; dirty tracking gates what is sent.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign read_data = mem_q[read_addr];

endmodule

`default_nettype wire

// File: rtl/sid_bus_sched.sv
// ============================================================================
// Module : sid_bus_sched
// Brief  : Replays dirty shadow-RAM entries onto the SID bus, phi2-aligned.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sid_bus_sched
  import sid_sched_pkg::*;
#(
  parameter int RAM_WIDTH     = 8,
  parameter int RAM_ADDR_BITS = $clog2(SID_NUM_REGS),
  parameter int PHI2_DIV      = SID_PHI2_DIV_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     host_wr_valid,
  input  logic [RAM_ADDR_BITS-1:0] host_wr_addr,
  input  logic [RAM_WIDTH-1:0]     host_wr_data,
  input  logic                     flush,
  output logic                     sid_phi2,
  output logic                     sid_cs_n,
  output logic                     sid_rw,
  output logic [RAM_ADDR_BITS-1:0] sid_addr,
  output logic [RAM_WIDTH-1:0]     sid_data,
  output logic                     sid_data_oe,
  output logic                     busy
);

  localparam int NREGS = 1 << RAM_ADDR_BITS;
  localparam int CNT_W = $clog2(PHI2_DIV);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(PHI2_DIV / 2);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PHI2_DIV - 1);

  sched_state_e             state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     phi2_q, phi2_d;
  logic                     cs_n_q, cs_n_d;
  logic                     rw_q, rw_d;
  logic                     oe_q, oe_d;
  logic [RAM_ADDR_BITS-1:0] addr_q, addr_d;
  logic [RAM_WIDTH-1:0]     data_q, data_d;
  logic [NREGS-1:0]         dirty_q, dirty_d;
  logic [RAM_ADDR_BITS-1:0] ptr_q, ptr_d;

  logic                     pick_found;
  logic [RAM_ADDR_BITS-1:0] pick_sel;
  logic [RAM_ADDR_BITS-1:0] pick_idx;
  logic                     take;
  logic [RAM_WIDTH-1:0]     ram_rdata;

  ram #(
    .RAM_WIDTH     (RAM_WIDTH),
    .RAM_ADDR_BITS (RAM_ADDR_BITS)
  ) u_ram (
    .clk       (clk),
    .we        (host_wr_valid),
    .wr_addr   (host_wr_addr),
    .wr_data   (host_wr_data),
    .read_addr (pick_sel),
    .read_data (ram_rdata)
  );

  // Round-robin: first dirty entry at or above ptr, wrapping modulo NREGS.
  always_comb begin
    pick_found = 1'b0;
    pick_sel   = ptr_q;
    pick_idx   = ptr_q;
    for (int i = 0; i < NREGS; i++) begin
      pick_idx = ptr_q + RAM_ADDR_BITS'(i);
      if (!pick_found && dirty_q[pick_idx]) begin
        pick_found = 1'b1;
        pick_sel   = pick_idx;
      end
    end
  end

  assign cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
  assign phi2_d = (cnt_d >= HALF);

  // Decisions key off cnt_d so the registered bus outputs line up with cnt.
  always_comb begin
    state_d = state_q;
    cs_n_d  = cs_n_q;
    rw_d    = rw_q;
    oe_d    = oe_q;
    addr_d  = addr_q;
    data_d  = data_q;
    ptr_d   = ptr_q;
    take    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cnt_d == '0 && pick_found) begin
          state_d = ST_SETUP;
          addr_d  = pick_sel;
          data_d  = ram_rdata;
          rw_d    = 1'b0;
          oe_d    = 1'b1;
          ptr_d   = pick_sel + RAM_ADDR_BITS'(1);
          take    = 1'b1;
        end
      end
      ST_SETUP: begin
        if (cnt_d == HALF) begin
          state_d = ST_STROBE;
          cs_n_d  = 1'b0;
        end
      end
      ST_STROBE: begin
        if (cnt_d == '0) begin
          state_d = ST_HOLD;
          cs_n_d  = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_d == HALF) begin
          state_d = ST_IDLE;
          oe_d    = 1'b0;
          rw_d    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Set beats clear, so a write landing in the select cycle is resent.
  always_comb begin
    dirty_d = dirty_q;
    if (take) begin
      dirty_d[pick_sel] = 1'b0;
    end
    if (host_wr_valid) begin
      dirty_d[host_wr_addr] = 1'b1;
    end
    if (flush) begin
      dirty_d = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      phi2_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      rw_q    <= 1'b1;
      oe_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      dirty_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phi2_q  <= phi2_d;
      cs_n_q  <= cs_n_d;
      rw_q    <= rw_d;
      oe_q    <= oe_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      dirty_q <= dirty_d;
      ptr_q   <= ptr_d;
    end
  end

  assign sid_phi2    = phi2_q;
  assign sid_cs_n    = cs_n_q;
  assign sid_rw      = rw_q;
  assign sid_addr    = addr_q;
  assign sid_data    = data_q;
  assign sid_data_oe = oe_q;
  assign busy        = (dirty_q != '0) || (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_sid_bus_sched.sv
// ============================================================================
// Module : tb_sid_bus_sched
// Brief  : Directed self-checking bench for sid_bus_sched with PHI2_DIV=8.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sid_bus_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       host_wr_valid;
  logic [4:0] host_wr_addr;
  logic [7:0] host_wr_data;
  logic       flush;
  logic       sid_phi2;
  logic       sid_cs_n;
  logic       sid_rw;
  logic [4:0] sid_addr;
  logic [7:0] sid_data;
  logic       sid_data_oe;
  logic       busy;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  logic [2:0] tb_cnt;

  sid_bus_sched #(
    .RAM_WIDTH     (8),
    .RAM_ADDR_BITS (5),
    .PHI2_DIV      (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .host_wr_valid (host_wr_valid),
    .host_wr_addr  (host_wr_addr),
    .host_wr_data  (host_wr_data),
    .flush         (flush),
    .sid_phi2      (sid_phi2),
    .sid_cs_n      (sid_cs_n),
    .sid_rw        (sid_rw),
    .sid_addr      (sid_addr),
    .sid_data      (sid_data),
    .sid_data_oe   (sid_data_oe),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Reference phase counter, independent of the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cnt <= 3'd0;
    else        tb_cnt <= tb_cnt + 3'd1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic wait_cnt(input logic [2:0] c);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (tb_cnt == c) break;
    end
  endtask

  task automatic host_write(input logic [4:0] a, input logic [7:0] d);
    host_wr_valid = 1'b1;
    host_wr_addr  = a;
    host_wr_data  = d;
    @(negedge clk);
    host_wr_valid = 1'b0;
  endtask

  task automatic next_strobe(output logic [4:0] a, output logic [7:0] d, output int t);
    logic prev;
    bit   got;
    prev = sid_cs_n;
    got  = 1'b0;
    a    = '1;
    d    = '0;
    t    = cyc;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clk);
      if (!sid_cs_n && prev) begin
        got = 1'b1;
        a   = sid_addr;
        d   = sid_data;
        t   = cyc;
      end
      prev = sid_cs_n;
    end
    if (!got) check("strobe_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic quiet_window(input string tag);
    int lows;
    int busies;
    lows   = 0;
    busies = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!sid_cs_n) lows++;
      if (busy) busies++;
    end
    check({tag, "_cs_lows"}, lows, 0);
    check({tag, "_busy"}, busies, 0);
  endtask

  initial begin
    logic [4:0]  a0, a1, a2;
    logic [7:0]  d0, d1, d2;
    int          t0, t1, t2;
    logic [15:0] v_cs, v_phi, v_oe, v_rw, v_busy;
    int          bad_addr, bad_gap;

    rst_n = 1'b0;
    host_wr_valid = 1'b0;
    host_wr_addr  = '0;
    host_wr_data  = '0;
    flush = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs_n", sid_cs_n, 1);
    check("rst_rw", sid_rw, 1);
    check("rst_oe", sid_data_oe, 0);
    check("rst_phi2", sid_phi2, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", sid_addr, 0);
    check("rst_data", sid_data, 0);
    rst_n = 1'b1;
    quiet_window("post_rst");

    // Single write at cnt=3, then a full 16-cycle bus waveform from cnt=0
    wait_cnt(3'd3);
    host_write(5'h18, 8'h0F);
    check("single_busy_rise", busy, 1);
    wait_cnt(3'd0);
    check("single_addr", sid_addr, 5'h18);
    check("single_data", sid_data, 8'h0F);
    check("single_rw", sid_rw, 0);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      v_cs[k]   = sid_cs_n;
      v_phi[k]  = sid_phi2;
      v_oe[k]   = sid_data_oe;
      v_rw[k]   = sid_rw;
      v_busy[k] = busy;
    end
    check("single_cs_wave", v_cs, 16'hFF0F);
    check("single_phi2_wave", v_phi, 16'hF0F0);
    check("single_oe_wave", v_oe, 16'h0FFF);
    check("single_rw_wave", v_rw, 16'hF000);
    check("single_busy_wave", v_busy, 16'h0FFF);
    check("single_addr_kept", sid_addr, 5'h18);

    // Round-robin: steer ptr to 0x05, then three back-to-back writes
    wait_cnt(3'd1);
    host_write(5'h04, 8'h44);
    next_strobe(a0, d0, t0);
    check("rr_pre_addr", a0, 5'h04);
    check("rr_pre_data", d0, 8'h44);
    wait_idle("rr_pre_idle");
    wait_cnt(3'd1);
    host_write(5'h00, 8'h11);
    host_write(5'h01, 8'h22);
    host_write(5'h1F, 8'h33);
    next_strobe(a0, d0, t0);
    next_strobe(a1, d1, t1);
    next_strobe(a2, d2, t2);
    check("rr_addr0", a0, 5'h1F);
    check("rr_data0", d0, 8'h33);
    check("rr_addr1", a1, 5'h00);
    check("rr_data1", d1, 8'h11);
    check("rr_addr2", a2, 5'h01);
    check("rr_data2", d2, 8'h22);
    check("rr_gap01", t1 - t0, 16);
    check("rr_gap12", t2 - t1, 16);
    wait_idle("rr_idle");

    // Collision: second write to 0x04 lands in the select cycle (cnt=7)
    wait_cnt(3'd3);
    host_write(5'h04, 8'hAA);
    wait_cnt(3'd7);
    host_write(5'h04, 8'h55);
    next_strobe(a0, d0, t0);
    next_strobe(a1, d1, t1);
    check("col_addr0", a0, 5'h04);
    check("col_data0", d0, 8'hAA);
    check("col_addr1", a1, 5'h04);
    check("col_data1", d1, 8'h55);
    check("col_gap", t1 - t0, 16);
    wait_idle("col_idle");

    // Flush from reset: 32 writes, addresses in order, 16 clk apart
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_cnt(3'd2);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_rise", busy, 1);
    bad_addr = 0;
    bad_gap  = 0;
    t1 = 0;
    for (int i = 0; i < 32; i++) begin
      next_strobe(a0, d0, t0);
      if (a0 != 5'(i)) bad_addr++;
      if (i > 0 && (t0 - t1) != 16) bad_gap++;
      t1 = t0;
    end
    check("flush_addr_order", bad_addr, 0);
    check("flush_gaps", bad_gap, 0);
    wait_idle("flush_idle");

    // Async reset during strobe, with a second entry still pending
    wait_cnt(3'd1);
    host_write(5'h07, 8'h77);
    host_write(5'h08, 8'h88);
    next_strobe(a0, d0, t0);
    check("arst_first_addr", a0, 5'h07);
    check("arst_cs_low", sid_cs_n, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cs_n", sid_cs_n, 1);
    check("arst_oe", sid_data_oe, 0);
    check("arst_rw", sid_rw, 1);
    check("arst_busy", busy, 0);
    check("arst_addr", sid_addr, 0);
    #1 rst_n = 1'b1;
    quiet_window("arst_after");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sid_bus_sched.md
# sid_bus_sched

Write-back scheduler for the SID register shadow RAM. The host side (ESP32 bus decode) writes registers into the 32x8 shadow RAM at full clock rate. This block tracks which entries are dirty and replays them onto the physical SID bus, one strobed write cycle at a time, aligned to a generated phi2. It owns the single RAM read port and sits between the host write decoder and the SID pins.

## Interface
- RAM_WIDTH, 8, SID data width
- RAM_ADDR_BITS, 5, SID register address width (32 entries)
- PHI2_DIV, 16, clk cycles per phi2 period; even, >= 4; H = PHI2_DIV/2
- clk  in  1  system clock; the only clock
- rst_n  in  1  reset, asynchronous, active-low
- host_wr_valid  in  1  host register write; accepted every cycle, no backpressure
- host_wr_addr  in  RAM_ADDR_BITS  host register address
- host_wr_data  in  RAM_WIDTH  host register data
- flush  in  1  single-cycle pulse; marks all entries dirty
- sid_phi2  out  1  generated SID clock
- sid_cs_n  out  1  SID chip select, active-low
- sid_rw  out  1  SID R/W; 0 = write
- sid_addr  out  RAM_ADDR_BITS  SID address bus
- sid_data  out  RAM_WIDTH  SID data bus value
- sid_data_oe  out  1  data bus driver enable
- busy  out  1  any dirty bit set, or state != IDLE

## Operation
- Host write: RAM[host_wr_addr] <= host_wr_data, and dirty[host_wr_addr] <= 1.
- Phase counter cnt runs 0..PHI2_DIV-1 and wraps. sid_phi2 = 0 for cnt 0..H-1 and 1 for cnt H..PHI2_DIV-1, registered.
- Selection: round-robin over the 32-bit dirty vector, searching upward from ptr with wrap. After a select of address a, ptr <= a+1 mod 32.
- FSM: IDLE, SETUP, STROBE, HOLD.
  - IDLE, cnt==0, dirty != 0 -> SETUP. Latch sid_addr=sel and sid_data=RAM[sel] (combinational read, RAM pre-write value). Set sid_rw=0, sid_data_oe=1, clear dirty[sel].
  - SETUP, cnt==H -> STROBE. sid_cs_n=0.
  - STROBE, cnt==0 -> HOLD. sid_cs_n=1. Address, data, rw and oe stay held; SID latches on this phi2 fall.
  - HOLD, cnt==H -> IDLE. sid_data_oe=0, sid_rw=1. sid_addr and sid_data keep their values.
- Each SID write occupies 2 phi2 periods.
- Simultaneous set and clear of the same dirty bit (host write, or flush, in the select cycle): set wins, so the entry is re-sent with the new data.
- Flush during an active cycle: the in-flight address is re-marked dirty. Flush does not touch ptr.
- RAM contents are not reset. Dirty is cleared on reset, so no entry is sent before it is written or flushed.

## Timing
- Reset values: cnt=0, sid_phi2=0, sid_cs_n=1, sid_rw=1, sid_data_oe=0, sid_addr=0, sid_data=0, dirty=0, ptr=0, state IDLE, busy=0.
- Reset mid-cycle: all outputs go to reset values asynchronously. The pending cycle is abandoned and not retried.
- Latency from host write at cnt=c to sid_addr valid, if the FSM is idle and no other entry is dirty: (PHI2_DIV-c) cycles. sid_cs_n then falls H cycles later.
- busy rises the cycle after host_wr_valid or flush. It falls in the cycle after the HOLD->IDLE transition when dirty==0.
- Throughput: one register per 2*PHI2_DIV clk cycles. A full flush takes 64 phi2 periods.

## Structure
- Shared package sid_sched_pkg holds:
  - the state encoding (IDLE, SETUP, STROBE, HOLD)
  - SID_NUM_REGS=32
  - default PHI2_DIV
- Sub-module: the existing distributed register RAM (module ram, RAM_WIDTH/RAM_ADDR_BITS passed through).
  - write port: host
  - read port: read_addr driven by the scheduler's selected address
- Round-robin picker stays inline, or goes in one helper sid_rr_pick: 32-bit vector plus ptr in, index and found out.

## Test plan
All scenarios use PHI2_DIV=8 (H=4).
- Reset: hold rst_n=0 -> sid_cs_n=1, sid_rw=1, sid_data_oe=0, sid_phi2=0, busy=0. Deassert with no writes -> sid_cs_n stays 1 for 100 cycles.
- Single write: addr 0x18, data 0x0F at cnt=3.
  - 5 cycles later (cnt=0): sid_addr=0x18, sid_data=0x0F, sid_rw=0.
  - sid_cs_n=0 for exactly cnt 4..7.
  - busy falls after HOLD.
- Round-robin: with ptr=0x05, write 0x00, 0x01, 0x1F on consecutive cycles -> SID cycles in order 0x1F, 0x00, 0x01, each 16 clk apart.
- Collision: host writes 0xAA then 0x55 to 0x04, the 0x55 write landing in the select cycle -> two SID writes to 0x04 carrying 0xAA then 0x55.
- Flush: pulse flush from reset -> 32 SID writes at addresses 0x00..0x1F in order, 16 clk apart; busy=0 afterward.
- Async reset: assert rst_n=0 while sid_cs_n=0 -> sid_cs_n=1 with no clk edge. After release, dirty=0 and no further SID cycles.
